delay_meter: RTL and testbench
==============================

DELAY_METER -- requirements
Module: delay_meter

Interface
REQ-001 Parameter CNT_W, default 8: width of the cycle counter and of the dly_out result.
REQ-002 Derived constant MAX_CNT = 2**CNT_W-1: the timeout threshold, in cycles.
REQ-003 clk  input  1: reference clock; all state updates on its rising edge.
REQ-004 rstn  input  1: reset, asynchronous and active-low.
REQ-005 start  input  1: single-cycle request to launch a measurement.
REQ-006 sig_in  input  1: echo signal whose first rising edge after launch ends the measurement; synchronous to clk.
REQ-007 clr  input  1: synchronous abort.
REQ-008 ready  input  1: consumer accepts the result.
REQ-009 dly_out  output  CNT_W: measured delay in clk cycles.
REQ-010 timeout  output  1: result is a timeout, not a measured edge.
REQ-011 valid  output  1: dly_out and timeout hold a result.
REQ-012 busy  output  1: block is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, COUNT and DONE.
REQ-014 The block SHALL register sig_in every cycle into sig_q; rise SHALL equal sig_in AND NOT sig_q.
REQ-015 IDLE: start=1 sampled at edge T0 SHALL move the FSM to COUNT with cnt=1; with start=0 the FSM SHALL stay in IDLE.
REQ-016 COUNT, rise=1 sampled at edge T1: the block SHALL load dly_out=cnt (= T1-T0 cycles), set timeout=0 and move to DONE.
REQ-017 COUNT, rise=0 and cnt=MAX_CNT: the block SHALL load dly_out=MAX_CNT, set timeout=1 and move to DONE.
REQ-018 COUNT, otherwise: cnt SHALL increment by 1; cnt SHALL never wrap.
REQ-019 An edge on sig_in in the same cycle start is sampled SHALL NOT count; only rises sampled in COUNT terminate a measurement.
REQ-020 A sig_in that is already high at launch SHALL require a low-to-high transition before it terminates a measurement.
REQ-021 DONE: valid SHALL be 1, and dly_out and timeout SHALL be held stable until valid AND ready.
REQ-022 valid AND ready SHALL return the FSM to IDLE with valid=0 on the following cycle.
REQ-023 start SHALL be ignored in COUNT and in DONE, including the cycle of the valid/ready handshake; no restart and no queueing.
REQ-024 clr SHALL have priority over every other input: from any state the FSM SHALL go to IDLE, with cnt=0, valid=0 and timeout=0.
REQ-025 After clr, dly_out SHALL retain its last value.
REQ-026 busy SHALL be 1 whenever the state is not IDLE, all outputs SHALL be registered, and valid SHALL first be seen 1 one cycle after the terminating edge.

Reset
REQ-027 rstn=0 SHALL asynchronously force: state=IDLE, cnt=0, sig_q=0, dly_out=0, timeout=0, valid=0, busy=0.
REQ-028 Reset asserted mid-COUNT or mid-DONE SHALL discard the pending result with no output glitch beyond the reset values.
REQ-029 The first start SHALL be honoured on the first rising edge after rstn deasserts.

Structure
REQ-030 A shared package delay_meter_pkg SHALL hold the state encoding (IDLE=2'b00, COUNT=2'b01, DONE=2'b10) and the default CNT_W.
REQ-031 The sig_q register and rise logic SHALL be one sub-module, edge_detect, reusable elsewhere in the sniffer.
REQ-032 The FSM, counter and result registers SHALL stay in delay_meter.

Verification
REQ-033 The bench SHALL feed start through a 2-stage shift register into sig_in, ready=1 -> dly_out=3, timeout=0, valid for 1 cycle.
REQ-034 The bench SHALL drive start with sig_in held 0, CNT_W=4 -> after 15 cycles dly_out=15, timeout=1, valid=1.
REQ-035 The bench SHALL hold ready=0 for 10 cycles after valid, pulsing start and toggling sig_in -> dly_out, timeout and valid stable; return to IDLE only after ready=1.
REQ-036 The bench SHALL hold sig_in high at start, drop it at +2 and raise it at +5 -> dly_out=5.
REQ-037 The bench SHALL assert clr at cnt=4 in COUNT, then start again with an echo at +6 -> busy=0 after clr; second result dly_out=6.
REQ-038 The bench SHALL pulse rstn low asynchronously mid-COUNT -> all outputs 0 immediately; next start measures correctly.

Source files
------------

// File: rtl/delay_meter_pkg.sv
// Shared state encoding and default counter width for the echo delay meter.
package delay_meter_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/delay_meter_edge_detect.sv
// Rising-edge detector: registers sig_in once per cycle, flags a 0->1 transition.
// Latency: rise is combinational from sig_in against the previous-cycle sample.
// Backpressure: none, free-running.
module edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic sig_in,
    output logic rise
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/delay_meter.sv
// Measures cycles from a start pulse to the first sig_in rise, saturating into a timeout.
// Latency: result registered, valid appears the cycle after the terminating edge.
// Backpressure: result held while ready is low; start is dropped while not idle.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             sig_in,
    input  logic             clr,
    input  logic             ready,
    output logic [CNT_W-1:0] dly_out,
    output logic             timeout,
    output logic             valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             rise;

    edge_detect u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .sig_in (sig_in),
        .rise   (rise)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dly_d     = dly_q;
        timeout_d = timeout_q;
        valid_d   = valid_q;

        // Abort wins over everything; the last delivered dly_out is kept.
        if (clr) begin
            state_d   = IDLE;
            cnt_d     = '0;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = COUNT;
                        cnt_d   = CNT_W'(1);
                    end
                end
                COUNT: begin
                    if (rise) begin
                        dly_d     = cnt_q;
                        timeout_d = 1'b0;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = DONE;
                    end else if (cnt_q == MAX_CNT) begin
                        dly_d     = MAX_CNT;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dly_q     <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dly_q     <= dly_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign dly_out = dly_q;
    assign timeout = timeout_q;
    assign valid   = valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: timestamp-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_delay_meter;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         sig_in;
    logic         clr;
    logic         ready;
    logic [W-1:0] dly_out;
    logic         timeout;
    logic         valid;
    logic         busy;

    always #5 clk = ~clk;

    delay_meter #(.CNT_W(W)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .sig_in  (sig_in),
        .clr     (clr),
        .ready   (ready),
        .dly_out (dly_out),
        .timeout (timeout),
        .valid   (valid),
        .busy    (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: a measurement is a launch timestamp; the result is elapsed cycles.
    bit m_meas, m_valid, m_to, m_prev;
    int m_t0, m_dly;

    // Echo generator: launch register followed by a 2-stage shift register.
    bit       echo_mode = 1'b0;
    bit       start_d   = 1'b0;
    bit [1:0] sr        = 2'b00;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_meas  = 1'b0;
        m_valid = 1'b0;
        m_to    = 1'b0;
        m_prev  = 1'b0;
        m_dly   = 0;
    endtask

    task automatic model_step();
        bit rise;
        int el;
        if (!rstn) begin
            model_reset();
            return;
        end
        rise   = sig_in && !m_prev;
        m_prev = sig_in;
        if (clr) begin
            m_meas  = 1'b0;
            m_valid = 1'b0;
            m_to    = 1'b0;
        end else if (m_valid) begin
            if (ready) m_valid = 1'b0;
        end else if (m_meas) begin
            el = cyc - m_t0;
            if (rise) begin
                m_dly = el; m_to = 1'b0; m_valid = 1'b1; m_meas = 1'b0;
            end else if (el == MAX) begin
                m_dly = MAX; m_to = 1'b1; m_valid = 1'b1; m_meas = 1'b0;
            end
        end else if (start) begin
            m_meas = 1'b1;
            m_t0   = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        sr      = {sr[0], start_d};
        start_d = start;
        @(negedge clk);
        check("dly_out", int'(dly_out), m_dly);
        check("timeout", int'(timeout), int'(m_to));
        check("valid",   int'(valid),   int'(m_valid));
        check("busy",    int'(busy),    int'(m_meas || m_valid));
        if (echo_mode) sig_in = sr[1];
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lit(input string name, input int d, input int t, input int v, input int b);
        check({name, " dly"},   int'(dly_out), d);
        check({name, " tmo"},   int'(timeout), t);
        check({name, " valid"}, int'(valid),   v);
        check({name, " busy"},  int'(busy),    b);
    endtask

    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; sig_in = 1'b0; clr = 1'b0; ready = 1'b1;
        model_reset();
        #12;
        lit("reset", 0, 0, 0, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // Echo through launch + 2-stage shift register returns after 3 cycles.
        echo_mode = 1'b1;
        launch();
        repeat (2) tick();
        tick();
        lit("echo", 3, 0, 1, 1);
        tick();
        check("echo valid one cycle", int'(valid), 0);
        echo_mode = 1'b0;
        sig_in = 1'b0;
        repeat (3) tick();

        // No echo: saturates into a timeout exactly MAX cycles after launch.
        launch();
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        check("timeout latency", n, 15);
        lit("timeout", 15, 1, 1, 1);
        tick();

        // Result held under backpressure while start and sig_in churn.
        ready = 1'b0;
        launch();
        repeat (3) tick();
        sig_in = 1'b1;
        tick();
        lit("hold first", 4, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            start  = 1'($urandom_range(1));
            sig_in = 1'($urandom_range(1));
            tick();
            lit("hold", 4, 0, 1, 1);
        end
        start = 1'b1;
        ready = 1'b1;
        tick();
        lit("handshake", 4, 0, 0, 0);
        start  = 1'b0;
        sig_in = 1'b0;
        tick();

        // sig_in already high at launch: needs a fresh low-to-high transition.
        sig_in = 1'b1;
        launch();
        tick();
        sig_in = 1'b0;
        repeat (3) tick();
        sig_in = 1'b1;
        tick();
        lit("prehigh", 5, 0, 1, 1);
        sig_in = 1'b0;
        tick();

        // Abort at cnt=4, then a clean measurement of 6.
        launch();
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        lit("clr", 5, 0, 0, 0);
        launch();
        repeat (5) tick();
        sig_in = 1'b1;
        tick();
        lit("after clr", 6, 0, 1, 1);
        sig_in = 1'b0;
        tick();

        // Asynchronous reset in the middle of a count.
        launch();
        repeat (2) tick();
        #2 rstn = 1'b0;
        #1;
        lit("async rst", 0, 0, 0, 0);
        model_reset();
        sr = 2'b00;
        start_d = 1'b0;
        tick();
        rstn = 1'b1;
        launch();
        repeat (6) tick();
        sig_in = 1'b1;
        tick();
        lit("post rst", 7, 0, 1, 1);
        sig_in = 1'b0;
        tick();

        // Randomized traffic; the quiet phase lets timeouts occur.
        for (int i = 0; i < 3000; i++) begin
            int tog;
            tog    = (i < 1500) ? 3 : 40;
            start  = ($urandom_range(3) == 0);
            if ($urandom_range(tog - 1) == 0) sig_in = ~sig_in;
            clr    = ($urandom_range(59) == 0);
            ready  = 1'($urandom_range(1));
            tick();
        end
        clr = 1'b0;
        start = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
